// File: rtl/btb_update_sched.sv
// BTB write-port scheduler: coalescing correction queue plus rollback override on one registered write port.
// Optional statistics counters are enabled by defining BTB_SCHED_STATS_EN.
module btb_update_sched #(
    parameter int WIDTH  = 2,
    parameter int QDEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       ex_valid,
    input  logic [WIDTH-1:0][31:0] ex_pc,
    input  logic [WIDTH-1:0][31:0] ex_target,
    input  logic [WIDTH-1:0]       ex_mismatch,
    output logic                   ex_ready,
    input  logic                   rb_valid,
    input  logic [31:0]            rb_pc,
    input  logic [31:0]            rb_target,
    input  logic                   rb_weak,
    output logic                   wr_valid,
    output logic [31:0]            wr_pc,
    output logic [31:0]            wr_target,
    input  logic                   wr_ready,
`ifdef BTB_SCHED_STATS_EN
    output logic [31:0]            stat_writes,
    output logic [31:0]            stat_coalesced,
    output logic [31:0]            stat_flushed,
`endif
    output logic                   busy
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ROOM = CW'(QDEPTH - WIDTH);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_RB    = 2'd2;

    logic [1:0]      state_r, state_nx_s;
    logic [31:0]     q_pc_r [QDEPTH];
    logic [31:0]     q_tgt_r [QDEPTH];
    logic [31:0]     q_pc_nx_s [QDEPTH];
    logic [31:0]     q_tgt_nx_s [QDEPTH];
    logic [PW-1:0]   head_r, tail_r, head_nx_s, tail_nx_s, off_s, hidx_s;
    logic [CW-1:0]   count_r, count_nx_s;
    logic [QDEPTH-1:0] live_s;
    logic            hit_s, match_s;
    logic [7:0]      coal_cnt_s;
    logic            pend_valid_r, pend_valid_nx_s;
    logic [31:0]     pend_pc_r, pend_tgt_r;
    logic            wr_valid_r, wr_valid_nx_s;
    logic [31:0]     wr_pc_r, wr_target_r, wr_pc_nx_s, wr_tgt_nx_s;
    logic            ex_ready_r, busy_r;
    logic [WIDTH-1:0] en_s;
    logic            hs_s, pop_s, pend_clr_s;

    assign en_s       = ex_valid & ex_mismatch & {WIDTH{ex_ready_r & ~rb_valid}};
    assign hs_s       = wr_valid_r & wr_ready;
    assign pop_s      = hs_s & (state_r == ST_DRAIN);
    assign pend_clr_s = hs_s & (state_r == ST_RB);

    // Queue next state: pop, lane-ordered coalesce/allocate, rollback flush.
    always_comb begin
        q_pc_nx_s  = q_pc_r;
        q_tgt_nx_s = q_tgt_r;
        coal_cnt_s = 8'd0;
        hit_s      = 1'b0;
        match_s    = 1'b0;
        hidx_s     = '0;
        off_s      = '0;
        live_s     = '0;
        for (int j = 0; j < QDEPTH; j++) begin
            off_s     = PW'(j) - head_r;
            live_s[j] = ({1'b0, off_s} < count_r) && !(pop_s && (PW'(j) == head_r));
        end
        head_nx_s  = pop_s ? (head_r + PTR_ONE) : head_r;
        count_nx_s = pop_s ? (count_r - CNT_ONE) : count_r;
        tail_nx_s  = tail_r;
        for (int i = 0; i < WIDTH; i++) begin
            hit_s  = 1'b0;
            hidx_s = '0;
            for (int j = 0; j < QDEPTH; j++) begin
                match_s = live_s[j] && (q_pc_nx_s[j] == ex_pc[i]) && !hit_s;
                hidx_s  = match_s ? PW'(j) : hidx_s;
                hit_s   = hit_s | match_s;
            end
            if (en_s[i] && hit_s) begin
                q_tgt_nx_s[hidx_s] = ex_target[i];
                coal_cnt_s         = coal_cnt_s + 8'd1;
            end else if (en_s[i]) begin
                q_pc_nx_s[tail_nx_s]  = ex_pc[i];
                q_tgt_nx_s[tail_nx_s] = ex_target[i];
                live_s[tail_nx_s]     = 1'b1;
                tail_nx_s             = tail_nx_s + PTR_ONE;
                count_nx_s            = count_nx_s + CNT_ONE;
            end else begin
                hit_s = 1'b0;
            end
        end
        head_nx_s  = rb_valid ? '0 : head_nx_s;
        tail_nx_s  = rb_valid ? '0 : tail_nx_s;
        count_nx_s = rb_valid ? '0 : count_nx_s;
    end

    // Pending rollback: a completing handshake clears first, then a weak rollback loads.
    always_comb begin
        if (rb_valid && rb_weak) begin
            pend_valid_nx_s = 1'b1;
        end else if (pend_clr_s) begin
            pend_valid_nx_s = 1'b0;
        end else begin
            pend_valid_nx_s = pend_valid_r;
        end
    end

    // Write-port FSM; the presented head target follows coalesced corrections.
    always_comb begin
        state_nx_s    = state_r;
        wr_valid_nx_s = wr_valid_r;
        wr_pc_nx_s    = wr_pc_r;
        wr_tgt_nx_s   = wr_target_r;
        if (rb_valid) begin
            state_nx_s    = ST_IDLE;
            wr_valid_nx_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pend_valid_r) begin
                        state_nx_s    = ST_RB;
                        wr_valid_nx_s = 1'b1;
                        wr_pc_nx_s    = pend_pc_r;
                        wr_tgt_nx_s   = pend_tgt_r;
                    end else if (count_r != '0) begin
                        state_nx_s    = ST_DRAIN;
                        wr_valid_nx_s = 1'b1;
                        wr_pc_nx_s    = q_pc_nx_s[head_r];
                        wr_tgt_nx_s   = q_tgt_nx_s[head_r];
                    end else begin
                        wr_valid_nx_s = 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (pend_valid_r) begin
                        state_nx_s    = ST_RB;
                        wr_valid_nx_s = 1'b1;
                        wr_pc_nx_s    = pend_pc_r;
                        wr_tgt_nx_s   = pend_tgt_r;
                    end else if (count_nx_s == '0) begin
                        state_nx_s    = ST_IDLE;
                        wr_valid_nx_s = 1'b0;
                    end else begin
                        wr_valid_nx_s = 1'b1;
                        wr_pc_nx_s    = q_pc_nx_s[head_nx_s];
                        wr_tgt_nx_s   = q_tgt_nx_s[head_nx_s];
                    end
                end
                ST_RB: begin
                    if (wr_ready) begin
                        state_nx_s    = ST_IDLE;
                        wr_valid_nx_s = 1'b0;
                    end else begin
                        wr_valid_nx_s = 1'b1;
                    end
                end
                default: begin
                    state_nx_s    = ST_IDLE;
                    wr_valid_nx_s = 1'b0;
                end
            endcase
        end
    end

    // State, queue and output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            head_r       <= '0;
            tail_r       <= '0;
            count_r      <= '0;
            pend_valid_r <= 1'b0;
            pend_pc_r    <= 32'd0;
            pend_tgt_r   <= 32'd0;
            wr_valid_r   <= 1'b0;
            wr_pc_r      <= 32'd0;
            wr_target_r  <= 32'd0;
            ex_ready_r   <= 1'b1;
            busy_r       <= 1'b0;
            for (int j = 0; j < QDEPTH; j++) begin
                q_pc_r[j]  <= 32'd0;
                q_tgt_r[j] <= 32'd0;
            end
        end else begin
            state_r      <= state_nx_s;
            head_r       <= head_nx_s;
            tail_r       <= tail_nx_s;
            count_r      <= count_nx_s;
            q_pc_r       <= q_pc_nx_s;
            q_tgt_r      <= q_tgt_nx_s;
            pend_valid_r <= pend_valid_nx_s;
            pend_pc_r    <= (rb_valid && rb_weak) ? rb_pc : pend_pc_r;
            pend_tgt_r   <= (rb_valid && rb_weak) ? rb_target : pend_tgt_r;
            wr_valid_r   <= wr_valid_nx_s;
            wr_pc_r      <= wr_pc_nx_s;
            wr_target_r  <= wr_tgt_nx_s;
            ex_ready_r   <= (count_nx_s <= CNT_ROOM);
            busy_r       <= (count_nx_s != '0) | pend_valid_nx_s;
        end
    end

    assign wr_valid  = wr_valid_r;
    assign wr_pc     = wr_pc_r;
    assign wr_target = wr_target_r;
    assign ex_ready  = ex_ready_r;
    assign busy      = busy_r;

`ifdef BTB_SCHED_STATS_EN
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    logic [31:0]   stat_writes_r, stat_coalesced_r, stat_flushed_r;
    logic [CW-1:0] dropped_s;
    assign dropped_s = count_r - {{(CW-1){1'b0}}, pop_s};

    // Saturating event counters; flushed counts entries still live after any same-edge pop.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stat_writes_r    <= 32'd0;
            stat_coalesced_r <= 32'd0;
            stat_flushed_r   <= 32'd0;
        end else begin
            stat_writes_r    <= sat_add(stat_writes_r, {31'd0, hs_s});
            stat_coalesced_r <= sat_add(stat_coalesced_r, {24'd0, coal_cnt_s});
            stat_flushed_r   <= sat_add(stat_flushed_r,
                                        rb_valid ? {{(32-CW){1'b0}}, dropped_s} : 32'd0);
        end
    end

    assign stat_writes    = stat_writes_r;
    assign stat_coalesced = stat_coalesced_r;
    assign stat_flushed   = stat_flushed_r;
`endif
endmodule
